// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, requester FSM states and the miss-read fill pattern
package cache_pkg;
  localparam int CACHE_ADDR_W = 7;
  localparam int CACHE_DATA_W = 32;
  localparam logic [31:0] MISS_PATTERN = 32'hDEADBEEF;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
endpackage

// File: rtl/cache_req_fifo.sv
// cache_req_fifo: sync FIFO (push/din in, pop/dout head, full/empty/count status), depth power of two
module cache_req_fifo #(
  parameter int W = 40,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(D);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/cache_cpu_requester.sv
// cache_cpu_requester: cmd_* FIFO in, one cpu_* cache transaction per command, rsp_* handshake out with timeout
module cache_cpu_requester
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_rw,
  output logic              cpu_valid,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cache_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_rw,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [7:0]        issued_count
);
  localparam int W = 1 + ADDR_W + DATA_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [TW-1:0] timer;
  logic [W-1:0] head;
  logic full, empty, pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  assign cmd_ready = !full;
  assign pop = state == IDLE && !empty;
  assign busy = |fifo_count || state != IDLE;
  cache_req_fifo #(.W(W), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(cmd_valid && cmd_ready),
    .pop(pop),
    .din({cmd_rw, cmd_addr, cmd_wdata}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      cpu_addr <= '0;
      cpu_din <= '0;
      cpu_rw <= 1'b0;
      cpu_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rw <= 1'b0;
      rsp_data <= '0;
      rsp_timeout <= 1'b0;
      issued_count <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          {cpu_rw, cpu_addr, cpu_din} <= head;
          cpu_valid <= 1'b1;
          timer <= '0;
          state <= ISSUE;
        end
        ISSUE: if (cache_ready) begin
          cpu_valid <= 1'b0;
          issued_count <= issued_count + 8'd1;
          state <= CAPTURE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          cpu_valid <= 1'b0;
          rsp_rw <= cpu_rw;
          rsp_data <= '0;
          rsp_timeout <= 1'b1;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else begin
          timer <= timer + 1'b1;
        end
        CAPTURE: begin
          rsp_data <= cpu_rw ? '0 : cpu_dout;
          rsp_rw <= cpu_rw;
          rsp_timeout <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        default: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_cpu_requester.sv
// tb_cache_cpu_requester: directed table, corner sequences and random traffic against a cache model and scoreboard
module tb_cache_cpu_requester;
  import cache_pkg::*;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_rw = 0, rsp_ready = 1;
  logic [6:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic cmd_ready, cpu_rw, cpu_valid, cache_ready, rsp_valid, rsp_rw, rsp_timeout, busy;
  logic [6:0] cpu_addr;
  logic [31:0] cpu_din, rsp_data;
  logic [31:0] cpu_dout = '0;
  logic [7:0] issued_count;
  bit force_low = 0, rand_mode = 0, rand_rsp = 0, rnd_ready = 1, expect_to = 0;
  int low_run = 0, vectors = 0, miscompares = 0, acc_count = 0, acc_mark = 0, rsp_cnt = 0;
  typedef struct {logic rw; logic [31:0] data; logic to;} exp_t;
  exp_t sb[$];
  logic [31:0] cmem [logic [6:0]];
  logic [31:0] rmem [logic [6:0]];
  typedef struct {logic rw; logic [6:0] addr; logic [31:0] wdata; logic [31:0] exp;} vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;
  assign cache_ready = !force_low && (!rand_mode || rnd_ready);

  cache_cpu_requester dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_rw(cpu_rw), .cpu_valid(cpu_valid), .cpu_dout(cpu_dout), .cache_ready(cache_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy), .issued_count(issued_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // cache model, command scoreboard and response checker, all sampled on pre-edge values
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      acc_mark = acc_count;
    end else begin
      if (cpu_valid && cache_ready) begin
        acc_count++;
        if (cpu_rw) cmem[cpu_addr] = cpu_din;
        else cpu_dout <= cmem.exists(cpu_addr) ? cmem[cpu_addr] : MISS_PATTERN;
      end
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.rw = cmd_rw;
        e.to = expect_to;
        e.data = (cmd_rw || expect_to) ? 32'h0 : (rmem.exists(cmd_addr) ? rmem[cmd_addr] : MISS_PATTERN);
        if (cmd_rw && !expect_to) rmem[cmd_addr] = cmd_wdata;
        sb.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("sb_unexpected_rsp", 32'(sb.size()), 32'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_rsp_rw", 32'(rsp_rw), 32'(e.rw));
          check("sb_rsp_data", rsp_data, e.data);
          check("sb_rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          check("sb_accepts_per_cmd", 32'(acc_count - acc_mark), e.to ? 32'd0 : 32'd1);
        end
        acc_mark = acc_count;
        rsp_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if ($urandom_range(0, 3) == 0 && low_run < 3) begin
      rnd_ready = 0;
      low_run++;
    end else begin
      rnd_ready = 1;
      low_run = 0;
    end
    if (rand_rsp) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic push(input logic rw, input logic [6:0] addr, input logic [31:0] data);
    bit got = 0;
    cmd_valid = 1;
    cmd_rw = rw;
    cmd_addr = addr;
    cmd_wdata = data;
    for (int i = 0; i < 200 && !got; i++) begin
      got = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 0;
    if (!got) check("push_accept", 32'd0, 32'd1);
  endtask

  task automatic wait_sig(input string name, input bit want_rsp);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      got = want_rsp ? rsp_valid : cpu_valid;
      if (!got) @(negedge clk);
    end
    if (!got) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int idx, n, a0, r0;
    logic [7:0] is0;
    tbl[0] = '{1'b1, 7'h05, 32'h12345678, 32'h0};
    tbl[1] = '{1'b0, 7'h05, 32'h0, 32'h12345678};
    tbl[2] = '{1'b0, 7'h12, 32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 7'h7F, 32'hA5A50F0F, 32'h0};
    tbl[4] = '{1'b0, 7'h7F, 32'h0, 32'hA5A50F0F};
    tbl[5] = '{1'b1, 7'h00, 32'hFFFFFFFF, 32'h0};
    tbl[6] = '{1'b0, 7'h00, 32'h0, 32'hFFFFFFFF};
    tbl[7] = '{1'b0, 7'h12, 32'h0, 32'hDEADBEEF};
    repeat (2) @(negedge clk);
    rst = 0;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_cpu_valid", 32'(cpu_valid), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_issued", 32'(issued_count), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);

    for (int i = 0; i < 8; i++) begin
      a0 = acc_count;
      push(tbl[i].rw, tbl[i].addr, tbl[i].wdata);
      wait_sig("tbl_rsp_wait", 1);
      check("tbl_rsp_rw", 32'(rsp_rw), 32'(tbl[i].rw));
      check("tbl_rsp_data", rsp_data, tbl[i].exp);
      check("tbl_rsp_timeout", 32'(rsp_timeout), 32'd0);
      check("tbl_one_accept", 32'(acc_count - a0), 32'd1);
      @(negedge clk);
      check("tbl_issued", 32'(issued_count), 32'(i + 1));
    end

    a0 = acc_count;
    force_low = 1;
    push(1'b0, 7'h05, 32'h0);
    wait_sig("stall_rise", 0);
    for (int k = 0; k < 4; k++) begin
      check("stall_valid_held", 32'(cpu_valid), 32'd1);
      check("stall_addr_held", 32'(cpu_addr), 32'h05);
      if (k == 3) force_low = 0;
      @(negedge clk);
    end
    check("stall_valid_drop", 32'(cpu_valid), 32'd0);
    check("stall_no_early_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    check("stall_rsp_data", rsp_data, 32'h12345678);
    check("stall_one_accept", 32'(acc_count - a0), 32'd1);
    @(negedge clk);

    is0 = issued_count;
    force_low = 1;
    expect_to = 1;
    push(1'b0, 7'h33, 32'h0);
    expect_to = 0;
    wait_sig("to_rise", 0);
    n = 0;
    while (cpu_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_valid_cycles", 32'(n), 32'd15);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    check("to_rsp_data", rsp_data, 32'd0);
    check("to_issued_same", 32'(issued_count), 32'(is0));
    force_low = 0;
    @(negedge clk);

    rsp_ready = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      bit ok;
      if (idx < 6) begin
        cmd_valid = 1;
        cmd_rw = 1'(idx % 2);
        cmd_addr = 7'(64 + idx);
        cmd_wdata = 32'(4096 + idx);
      end
      ok = cmd_ready && idx < 6;
      @(negedge clk);
      if (ok) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd5);
    check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    cmd_valid = 0;
    r0 = rsp_cnt;
    rsp_ready = 1;
    for (int i = 0; i < 200 && rsp_cnt - r0 < 5; i++) @(negedge clk);
    check("bp_rsp_count", 32'(rsp_cnt - r0), 32'd5);

    rand_mode = 1;
    rand_rsp = 1;
    for (int i = 0; i < 40; i++)
      push(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom);
    n = 0;
    while ((busy || rsp_valid) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    rand_rsp = 0;
    rand_mode = 0;
    rsp_ready = 1;
    check("rand_drained", 32'(busy), 32'd0);
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("issued_vs_accepts", 32'(issued_count), 32'(acc_count % 256));
    @(negedge clk);

    force_low = 1;
    push(1'b1, 7'h10, 32'h55);
    wait_sig("rst_rise", 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_issued", 32'(issued_count), 32'd0);
    force_low = 0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_cpu_requester.md
Name: cache_cpu_requester

Overview:
CPU-side initiator for the cache request port: the block that drives cpu_addr/cpu_din/cpu_rw/cpu_valid and consumes cache_ready/cpu_dout.
- Accepts read/write commands from a test or host source through a small command FIFO.
- Issues each command as exactly one cache transaction and captures read data one cycle after acceptance.
- Returns a response through a valid/ready handshake, with a timeout if the cache never becomes ready.

Parameters:
ADDR_W, 7, cache address width
DATA_W, 32, data width
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 15, max cycles cpu_valid waits for cache_ready before abort (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_rw  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  write data
cpu_addr  out  ADDR_W  to cache
cpu_din  out  DATA_W  write data to cache
cpu_rw  out  1  to cache
cpu_valid  out  1  request strobe to cache
cpu_dout  in  DATA_W  read data from cache (registered in cache)
cache_ready  in  1  cache accepts when high at posedge with cpu_valid
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_rw  out  1  rw of completed command
rsp_data  out  DATA_W  read data; 0 for writes and timeouts
rsp_timeout  out  1  command aborted by timeout
busy  out  1  FIFO non-empty or FSM not IDLE
issued_count  out  8  accepted cache transactions, wraps 255->0

Behaviour:
- Reset, synchronous: all outputs 0 except cmd_ready=1; FIFO emptied; FSM=IDLE; timeout counter 0. Reset mid-transaction drops cpu_valid on the next edge and discards any pending response.
- FIFO: push when cmd_valid && cmd_ready. cmd_ready = !full, registered-state only; it does not depend on a same-cycle pop. Pop only in the IDLE->ISSUE transition. Pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop while not full updates both with the count unchanged.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop head into the cpu_* registers, set cpu_valid=1, clear the timer, go to ISSUE.
  - ISSUE: cpu_valid held high with cpu_addr/din/rw stable.
    - If cache_ready=1 at the edge: transaction accepted; cpu_valid=0 next cycle; issued_count+1; go to CAPTURE.
    - Otherwise timer+1. When the timer reaches TIMEOUT with no acceptance: cpu_valid=0, rsp_timeout=1, rsp_data=0, rsp_valid=1, go to RESP.
  - CAPTURE: one cycle. rsp_data = cpu_rw ? 0 : cpu_dout sampled this cycle; rsp_rw = cpu_rw; rsp_timeout=0; rsp_valid=1; go to RESP.
  - RESP: hold rsp_* stable until rsp_valid && rsp_ready. Then rsp_valid=0 and go to IDLE. The next command can issue no earlier than the cycle after IDLE.
- cpu_valid is never high outside ISSUE. The cache executes on every cycle valid && ready, so one command must produce exactly one cpu_valid&&cache_ready edge.
- Minimum latency: pop-to-rsp_valid is 3 cycles (IDLE, ISSUE with ready=1, CAPTURE). At most one transaction is outstanding.
- cache_ready low at the instant cpu_valid rises is the normal stall case, not an error.
- busy is combinational from FIFO count and state.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W/DATA_W defaults
  - FSM state enum {IDLE, ISSUE, CAPTURE, RESP}
  - miss-read pattern constant 32'hDEADBEEF, used by benches
- One sub-module, cache_req_fifo: synchronous FIFO parameterised on width (1+ADDR_W+DATA_W) and depth, with full/empty/count.
- FSM, timer and response registers stay in the top.

Test Plan:
- Write addr 0x05 data 0x12345678, then read 0x05 against the cache controller with rsp_ready=1. Write rsp: rsp_rw=1, rsp_data=0. Read rsp: rsp_data=0x12345678, rsp_timeout=0. issued_count=2.
- Read addr 0x12 from reset (miss) -> rsp_data=0xDEADBEEF. Exactly one cpu_valid&&cache_ready edge.
- Hold cache_ready low for 3 cycles after cpu_valid rises -> cpu_valid and cpu_addr stay stable 4 cycles, a single acceptance, response 1 cycle after acceptance.
- Hold cache_ready low permanently with TIMEOUT=15 -> cpu_valid high exactly 15 cycles then low. rsp_timeout=1, rsp_data=0, issued_count unchanged.
- Push 6 commands back-to-back with rsp_ready=0 -> 5 accepted (1 in flight plus 4 queued). cmd_ready low until rsp_ready is raised. Responses then arrive in push order.
- Assert rst for 1 cycle while in ISSUE -> next cycle cpu_valid=0, rsp_valid=0, cmd_ready=1, busy=0, issued_count=0.
